// File: rtl/ps2_wb8.sv
// rtl/ps2_wb8.sv - PS/2 device-to-host receiver with a byte FIFO behind an 8-bit wishbone slave.
// Never drives the PS/2 lines.
module ps2_wb8 #(
  parameter int CLOCKFREQ = 25125000,
  parameter int FIFOBITS  = 3,
  parameter int FILTERLEN = 8
) (
  input  logic       I_wb_clk,
  input  logic       I_reset_n,
  input  logic [1:0] I_wb_adr,
  input  logic [7:0] I_wb_dat,
  input  logic       I_wb_stb,
  input  logic       I_wb_we,
  output logic [7:0] O_wb_dat,
  output logic       O_wb_ack,
  output logic       O_interrupt,
  input  logic       I_ps2_clk,
  input  logic       I_ps2_data
);

  localparam int TIMEOUT = CLOCKFREQ / 1000;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int FW      = $clog2(FILTERLEN + 1);
  localparam int DEPTH   = 1 << FIFOBITS;
  localparam int CW      = FIFOBITS + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          push_q, push_d;
  logic          perr_set, ferr_set;

  logic [7:0]          mem_q [DEPTH];
  logic [FIFOBITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ferr_q, ferr_d, perr_q, perr_d, ovf_q, ovf_d;
  logic                irq_en_q, irq_en_d;
  logic [7:0]          dat_q, dat_d;
  logic                ack_q, ack_d, irq_q, irq_d;
  logic                first, pop, wr_ok, empty, full;
  logic [2:0]          clr;
  logic [7:0]          rdata;
  logic                unused_bits;

  assign unused_bits = ^{I_wb_dat[7:5], I_wb_dat[1]};

  // Filtered clock only follows the synchronised line after FILTERLEN differing samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTERLEN - 1)) begin
      filt_d = ~filt_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tcnt_d   = '0;
    push_d   = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (state_q == IDLE) begin
      if (fall && !dat_s2_q) begin
        state_d  = DATA;
        bitcnt_d = '0;
      end
    end else if (fall) begin
      case (state_q)
        DATA: begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!dat_s2_q)                   ferr_set = 1'b1;
          else if (!(^{shreg_q, par_q}))   perr_set = 1'b1;
          else                             push_d   = 1'b1;
        end
      endcase
    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
      // Device stalled mid-frame: abandon it so the next start bit resynchronises.
      ferr_set = 1'b1;
      state_d  = IDLE;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    first = I_wb_stb & ~ack_q;
    pop   = first & ~I_wb_we & (I_wb_adr == 2'd0) & ~empty;
    wr_ok = push_q & (~full | pop);
    clr   = (first && I_wb_we && I_wb_adr == 2'd1) ? I_wb_dat[4:2] : 3'b000;

    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (wr_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_ok) count_d = count_q - 1'b1;

    // A flag being set in the same cycle as its clear stays set.
    ferr_d = (ferr_q & ~clr[2]) | ferr_set;
    perr_d = (perr_q & ~clr[1]) | perr_set;
    ovf_d  = (ovf_q  & ~clr[0]) | (push_q & ~wr_ok);

    irq_en_d = irq_en_q;
    if (first && I_wb_we && I_wb_adr == 2'd2) irq_en_d = I_wb_dat[0];

    case (I_wb_adr)
      2'd0:    rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
      2'd1:    rdata = {3'b000, ferr_q, perr_q, ovf_q, full, ~empty};
      2'd2:    rdata = {7'b0, irq_en_q};
      default: rdata = 8'(count_q);
    endcase
    dat_d = I_wb_stb ? rdata : dat_q;
    ack_d = I_wb_stb;
    irq_d = irq_en_q & ~empty;
  end

  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
      push_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      clk_s1_q <= I_ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= I_ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
      push_q   <= push_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge I_wb_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign O_wb_dat    = dat_q;
  assign O_wb_ack    = ack_q;
  assign O_interrupt = irq_q;

endmodule

// File: tb/tb_ps2_wb8.sv
// tb/tb_ps2_wb8.sv - Self-checking bench for ps2_wb8: register table, directed corner cases, random frames vs. a queue model.
module tb_ps2_wb8;
  localparam int HB = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] adr = '0;
  logic [7:0] wdat = '0;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic [7:0] rdat;
  logic       ack, irq;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  bit m_ferr, m_perr, m_ovf;

  typedef struct {
    logic [1:0] adr;
    logic       we;
    logic [7:0] wdat;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[12];

  ps2_wb8 #(.CLOCKFREQ(100000), .FIFOBITS(3), .FILTERLEN(8)) dut (
    .I_wb_clk(clk), .I_reset_n(rst_n), .I_wb_adr(adr), .I_wb_dat(wdat),
    .I_wb_stb(stb), .I_wb_we(we), .O_wb_dat(rdat), .O_wb_ack(ack),
    .O_interrupt(irq), .I_ps2_clk(ps2_clk), .I_ps2_data(ps2_dat)
  );

  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wb(input logic [1:0] a, input logic w, input logic [7:0] d, output logic [7:0] r);
    @(negedge clk);
    adr = a; we = w; wdat = d; stb = 1'b1;
    @(negedge clk);
    r = rdat;
    chk("ack", {7'b0, ack}, 8'h01);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] r;
    wb(a, 1'b0, 8'h00, r);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] r;
    wb(a, 1'b1, d, r);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (HB / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HB) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HB / 2) @(negedge clk);
    end
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    if (!stop) m_ferr = 1;
    else if (bad_par) m_perr = 1;
    else if (mq.size() < 8) mq.push_back(b);
    else m_ovf = 1;
  endtask

  task automatic model_status();
    logic [7:0] s;
    s = {3'b0, m_ferr, m_perr, m_ovf, mq.size() == 8, mq.size() != 0};
    rd_chk("status", 2'd1, s);
    rd_chk("count", 2'd3, 8'(mq.size()));
  endtask

  task automatic model_drain();
    while (mq.size() > 0) rd_chk("fifo_data", 2'd0, mq.pop_front());
    rd_chk("fifo_empty_read", 2'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    int e;

    tbl[0]  = '{2'd0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{2'd1, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{2'd2, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{2'd3, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{2'd2, 1'b1, 8'hFE, 8'h00};
    tbl[5]  = '{2'd2, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{2'd2, 1'b1, 8'hFF, 8'h00};
    tbl[7]  = '{2'd2, 1'b0, 8'h00, 8'h01};
    tbl[8]  = '{2'd0, 1'b1, 8'h5A, 8'h00};
    tbl[9]  = '{2'd3, 1'b1, 8'h77, 8'h00};
    tbl[10] = '{2'd3, 1'b0, 8'h00, 8'h00};
    tbl[11] = '{2'd2, 1'b1, 8'h00, 8'h00};

    repeat (4) @(negedge clk);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    chk("reset_dat", rdat, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) wr(tbl[i].adr, tbl[i].wdat);
      else rd_chk($sformatf("table_%0d", i), tbl[i].adr, tbl[i].exp);
    end

    // Single good frame with interrupt enabled
    wr(2'd2, 8'h01);
    send(8'h1C, 0, 1, 11);
    rd_chk("t2_status", 2'd1, 8'h01);
    rd_chk("t2_count", 2'd3, 8'h01);
    chk("t2_irq_set", {7'b0, irq}, 8'h01);
    rd_chk("t2_data", 2'd0, 8'h1C);
    chk("t2_irq_clr", {7'b0, irq}, 8'h00);
    rd_chk("t2_status_after", 2'd1, 8'h00);

    // Parity error then framing error, then write-1-to-clear
    send(8'hF0, 1, 1, 11);
    send(8'hAA, 0, 0, 11);
    rd_chk("t3_status", 2'd1, 8'h18);
    rd_chk("t3_count", 2'd3, 8'h00);
    wr(2'd1, 8'h18);
    rd_chk("t3_cleared", 2'd1, 8'h00);

    // Overflow on the ninth byte
    for (int i = 1; i <= 9; i++) send(8'(i), 0, 1, 11);
    rd_chk("t4_count", 2'd3, 8'h08);
    rd_chk("t4_status", 2'd1, 8'h07);
    for (int i = 1; i <= 8; i++) rd_chk("t4_data", 2'd0, 8'(i));
    rd_chk("t4_empty", 2'd0, 8'h00);
    wr(2'd1, 8'h1C);
    rd_chk("t4_cleared", 2'd1, 8'h00);

    // Stalled partial frame times out
    send(8'h00, 0, 1, 4);
    repeat (150) @(negedge clk);
    rd_chk("t5_timeout", 2'd1, 8'h10);
    wr(2'd1, 8'h10);
    send(8'h55, 0, 1, 11);
    rd_chk("t5_data", 2'd0, 8'h55);
    rd_chk("t5_status", 2'd1, 8'h00);

    // Held strobe pops exactly once
    send(8'h11, 0, 1, 11);
    send(8'h22, 0, 1, 11);
    @(negedge clk);
    adr = 2'd0; we = 1'b0; stb = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_held_dat", rdat, 8'h22);
    stb = 1'b0;
    @(negedge clk);
    rd_chk("t6_count", 2'd3, 8'h01);
    rd_chk("t6_data", 2'd0, 8'h22);

    // Single-cycle clock glitches with data low must not start a frame
    ps2_dat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ps2_clk = 1'b0;
      @(negedge clk); ps2_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
    repeat (150) @(negedge clk);
    ps2_dat = 1'b1;
    rd_chk("t6_glitch_status", 2'd1, 8'h00);
    rd_chk("t6_glitch_count", 2'd3, 8'h00);

    // Random frames against the queue model
    m_ferr = 0; m_perr = 0; m_ovf = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      e = int'($urandom_range(0, 5));
      send(b, e == 0, e != 1, 11);
      model_frame(b, e == 0, e != 1);
      model_status();
      if ($urandom_range(0, 3) == 0) begin
        model_drain();
        wr(2'd1, 8'h1C);
        m_ferr = 0; m_perr = 0; m_ovf = 0;
      end
    end
    model_drain();
    model_status();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
